reg_write_arbiter: RTL

- Shares the write side of a bank of NREG single-write-port registers between NREQ requesters (e.g. ALU result, load unit, immediate load, PC update).
- Round-robin arbitration with a req/gnt handshake.
- Captures the winning address and data, then drives one registered one-hot write enable and a shared data bus into the register bank one cycle later.
- Sits between the execute/load stages and the register bank.

---
 rtl/reg_write_arbiter_if.sv | 36 +++
 rtl/reg_write_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/reg_write_arbiter_if.sv
// Write-port bus between the requesters and the register-write arbiter.
//
// Handshake: requester i holds req[i] high with req_addr/req_data stable
// until gnt[i] is high. The transfer completes on the posedge at which gnt[i]
// is high. Keeping req[i] high after that edge requests a new write. Dropping
// req[i] before the grant withdraws the request, and no write occurs.
// freeze stops any new grant. gnt is combinational from req, freeze and the
// round-robin pointer.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int AW    = 3
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  freeze;
  logic [NREQ-1:0]       gnt;
  logic [NREG-1:0]       w_en;
  logic [AW-1:0]         w_addr;
  logic [WIDTH-1:0]      w_data;
  logic [2:0]            last_gnt;
  logic                  err_oor;
  logic [2:0]            rr_ptr;   // debug view of the round-robin pointer

  modport master (
    output req, req_addr, req_data, freeze,
    input  gnt, w_en, w_addr, w_data, last_gnt, err_oor, rr_ptr
  );

  modport slave (
    input  req, req_addr, req_data, freeze,
    output gnt, w_en, w_addr, w_data, last_gnt, err_oor, rr_ptr
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single write port of a register bank.
// The winning address and data are captured on the grant edge. They are
// presented one cycle later as a one-hot write enable with a shared data bus.
// Out-of-range addresses are accepted but never written, and they set a
// sticky error flag.
module reg_write_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input logic               clk,
  input logic               rst,
  reg_write_arbiter_if.slave bus
);

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  arb_gnt;
  logic             found;
  logic [2:0]       win;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic             in_range;
  logic [NREG-1:0]  onehot;
  logic [2:0]       rr_next;

  logic [2:0]       rr_ptr;
  logic [NREG-1:0]  w_en_q;
  logic [AW-1:0]    w_addr_q;
  logic [WIDTH-1:0] w_data_q;
  logic [2:0]       last_gnt_q;
  logic             err_q;

  assign eligible = bus.req & {NREQ{~bus.freeze}};

  // Search upward from the pointer with wrap-around. The first eligible requester wins.
  always_comb begin
    arb_gnt  = '0;
    found    = 1'b0;
    win      = 3'd0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && eligible[j] && (((int'(rr_ptr) + i) % NREQ) == j)) begin
          found      = 1'b1;
          arb_gnt[j] = 1'b1;
          win        = 3'(j);
          win_addr   = bus.req_addr[j*AW +: AW];
          win_data   = bus.req_data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Decode the winning address into a bank enable, and advance the pointer past the winner.
  always_comb begin
    onehot   = '0;
    in_range = (int'(win_addr) < NREG);
    for (int j = 0; j < NREG; j++) begin
      onehot[j] = (int'(win_addr) == j);
    end
    rr_next = (int'(win) == NREQ - 1) ? 3'd0 : win + 3'd1;
  end

  // Capture the accepted write. Without a grant, w_en drops and everything else holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= 3'd0;
      w_en_q     <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      last_gnt_q <= 3'd0;
      err_q      <= 1'b0;
    end else if (found) begin
      w_addr_q   <= win_addr;
      w_data_q   <= win_data;
      w_en_q     <= in_range ? onehot : '0;
      last_gnt_q <= win;
      rr_ptr     <= rr_next;
      if (!in_range) err_q <= 1'b1;
    end else begin
      w_en_q <= '0;
    end
  end

  // While reset is asserted, the grant is held low even if requests are pending.
  assign bus.gnt      = rst ? arb_gnt : '0;
  assign bus.w_en     = w_en_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.last_gnt = last_gnt_q;
  assign bus.err_oor  = err_q;
  assign bus.rr_ptr   = rr_ptr;

endmodule
